// File: rtl/i2s_tx.sv
// I2S stereo transmitter: mono sample duplicated to L/R.
// One-entry holding buffer with underrun/overrun pulses.
module i2s_tx #(
  parameter int unsigned BCLK_DIV      = 4,
  parameter bit          OFFSET_BINARY = 1'b1
) (
  input  logic        MHz10,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_req,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun,
  output logic        overrun
);

  logic [7:0]  r_div_cnt;
  logic        r_bclk;
  logic        r_lrclk;
  logic        r_sdata;
  logic        r_req;
  logic        r_und;
  logic        r_ovr;
  logic [4:0]  r_slot;
  logic [31:0] r_shift;
  logic        r_pend;
  logic [15:0] r_hold;
  logic [15:0] r_last;

  logic        w_tick;
  logic        w_fall;
  logic        w_load;
  logic [4:0]  w_slot_nx;
  logic [15:0] w_word;
  logic [15:0] w_conv;

  // Falling-edge event, frame load and word conversion
  always_comb begin
    w_tick    = (r_div_cnt == 8'(BCLK_DIV - 1));
    w_fall    = en & w_tick & r_bclk;
    w_slot_nx = r_slot + 5'd1;
    w_load    = w_fall & (r_slot == 5'd31);
    w_word    = r_pend ? r_hold : r_last;
    w_conv    = w_word;
    if (OFFSET_BINARY)
      w_conv = {~w_word[15], w_word[14:0]};
  end

  // Bit-clock divider
  always_ff @(posedge MHz10) begin
    if (rst) begin
      r_div_cnt <= 8'd0;
      r_bclk    <= 1'b0;
    end else if (en) begin
      if (w_tick) begin
        r_div_cnt <= 8'd0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + 8'd1;
      end
    end
  end

  // Slot counter and serializer, advanced on bclk falls
  always_ff @(posedge MHz10) begin
    if (rst) begin
      r_slot  <= 5'd31;
      r_shift <= 32'd0;
      r_sdata <= 1'b0;
      r_lrclk <= 1'b0;
    end else if (w_fall) begin
      r_slot  <= w_slot_nx;
      r_sdata <= r_shift[31];
      r_lrclk <= w_slot_nx[4];
      if (w_load)
        r_shift <= {w_conv, w_conv};
      else
        r_shift <= {r_shift[30:0], 1'b0};
    end
  end

  // Holding register; a load frees it before a same-cycle capture
  always_ff @(posedge MHz10) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_hold <= 16'd0;
      r_last <= 16'd0;
    end else if (en) begin
      if (w_load) begin
        r_last <= w_word;
        r_pend <= 1'b0;
      end
      if (sample_valid) begin
        r_hold <= sample_in;
        r_pend <= 1'b1;
      end
    end
  end

  // Single-cycle status pulses
  always_ff @(posedge MHz10) begin
    if (rst) begin
      r_req <= 1'b0;
      r_und <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_req <= w_load;
      r_und <= w_load & ~r_pend;
      r_ovr <= en & sample_valid & r_pend & ~w_load;
    end
  end

  assign sample_req = r_req;
  assign bclk       = r_bclk;
  assign lrclk      = r_lrclk;
  assign sdata      = r_sdata;
  assign underrun   = r_und;
  assign overrun    = r_ovr;

endmodule
